dom_rand_gen: RTL and testbench
===============================

DOM_RAND_GEN -- requirements
Module: dom_rand_gen

Interface
REQ-001 SHALL have parameter SHARES, default 2, number of DOM shares of the consuming shared_mul_gf4; legal range 2..6.
REQ-002 SHALL have parameter WARMUP, default 8, number of discard cycles after each seed load; legal range 0..255.
REQ-003 SHALL define localparam RW = 2*SHARES*(SHARES-1), randomness bits per cycle, equal to the consumer's _ZxDI width.
REQ-004 SHALL have ClkxCI  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have RstxBI  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have SeedxDI  input  64  LFSR seed value.
REQ-007 SHALL have SeedValidxSI  input  1  load SeedxDI on this edge.
REQ-008 SHALL have EnxSI  input  1  consumer requests a fresh RW-bit word this cycle.
REQ-009 SHALL have _ZxDO  output  RW  registered fresh randomness, wired directly to the consumer's _ZxDI.
REQ-010 SHALL have ZValidxSO  output  1  _ZxDO was refreshed on the last edge.
REQ-011 SHALL have BusyxSO  output  1  generator unseeded or warming up; _ZxDO is not usable.

Function
REQ-012 SHALL hold a 64-bit Fibonacci LFSR state S, polynomial x^64+x^63+x^61+x^60+1.
REQ-013 SHALL define one step as b = S[63]^S[62]^S[60]^S[59]; S <= {S[62:0], b}.
REQ-014 SHALL define an advance as exactly RW steps unrolled combinationally within one cycle.
REQ-015 SHALL implement FSM states IDLE (unseeded), WARM, RUN.
REQ-016 SHALL load S from SeedxDI on any edge with SeedValidxSI=1, in any state; this has priority over advance and enable.
- All-zero seed SHALL load 64'h1.
REQ-017 On a seed load, the FSM SHALL go to WARM with warm counter 0, or to RUN directly if WARMUP=0.
REQ-018 In WARM, S SHALL advance every cycle regardless of EnxSI, and the counter SHALL increment.
- After WARMUP advances, the FSM SHALL go to RUN.
- _ZxDO SHALL stay 0 and ZValidxSO SHALL stay 0 throughout WARM.
REQ-019 In RUN with EnxSI=1 and no seed load:
- S SHALL advance.
- _ZxDO SHALL be set to the advanced S[RW-1:0].
- ZValidxSO SHALL be 1 in the next cycle (latency 1).
REQ-020 In RUN with EnxSI=0:
- S and _ZxDO SHALL hold.
- ZValidxSO SHALL be 0.
REQ-021 In IDLE, S SHALL hold, EnxSI SHALL be ignored, and _ZxDO SHALL stay 0.
REQ-022 BusyxSO SHALL be 1 in IDLE and WARM, and 0 in RUN.
REQ-023 A reseed in RUN SHALL clear _ZxDO and ZValidxSO on the same edge; the FSM re-enters WARM (or RUN if WARMUP=0).
REQ-024 Back-to-back EnxSI=1 SHALL produce a new word every cycle with no bubble.
REQ-025 The warm counter SHALL be 8 bits; it SHALL not wrap, and SHALL reset to 0 on every seed load.

Reset
REQ-026 RstxBI=0 SHALL immediately (asynchronously) set S=64'h1, FSM=IDLE, counter=0, _ZxDO=0, ZValidxSO=0, BusyxSO=1.
REQ-027 Reset asserted mid-RUN SHALL discard the seed; the block SHALL require a new SeedValidxSI after RstxBI returns to 1.

Verification
REQ-028 Reset check: assert RstxBI=0 between clock edges -> _ZxDO=0, ZValidxSO=0 and BusyxSO=1 immediately; EnxSI=1 with no seed -> outputs unchanged.
REQ-029 SHARES=2, WARMUP=0: seed 64'h8000_0000_0000_0000, then EnxSI=1 for one cycle -> _ZxDO=4'h8, ZValidxSO=1, BusyxSO=0.
REQ-030 SHARES=2, WARMUP=8: seed, then EnxSI=1 held -> BusyxSO=1 for exactly 8 cycles, then ZValidxSO=1 every cycle.
- Words SHALL match a software model of REQ-013/014 advanced 8 times before the first word.
REQ-031 Zero-seed check: SeedxDI=0 -> behaviour identical to SeedxDI=64'h1, and S never becomes 0.
REQ-032 Stall/reseed check in RUN: EnxSI toggles -> _ZxDO holds and ZValidxSO=0 on idle cycles.
- Reseed with EnxSI=1 on the same edge -> seed wins: _ZxDO=0 and BusyxSO=1 next cycle.
REQ-033 SHARES=3 (RW=12) with a 10000-cycle random EnxSI pattern -> bit-exact match to the model, and the _ZxDO width SHALL equal the consumer's _ZxDI width.

Source files
------------

// File: rtl/dom_rand_gen.sv
// dom_rand_gen: fresh-randomness source for a DOM-masked shared_mul_gf4.
//
// A 64-bit Fibonacci LFSR (x^64+x^63+x^61+x^60+1) is advanced RW steps per
// cycle. After each seed load the generator discards WARMUP advances, then
// hands out one RW-bit word per cycle that the consumer asserts EnxSI.
//
// Ports:
//   ClkxCI        in   1   clock, rising edge
//   RstxBI        in   1   asynchronous active-low reset
//   SeedxDI       in   64  LFSR seed (all-zero is mapped to 64'h1)
//   SeedValidxSI  in   1   load SeedxDI on this edge (highest priority)
//   EnxSI         in   1   request a fresh word this cycle
//   _ZxDO         out  RW  registered randomness for the consumer's _ZxDI
//   ZValidxSO     out  1   _ZxDO was refreshed on the last edge
//   BusyxSO       out  1   unseeded or warming up; _ZxDO not usable
module dom_rand_gen #(
  parameter int unsigned SHARES = 2,
  parameter int unsigned WARMUP = 8,
  localparam int unsigned RW = 2 * SHARES * (SHARES - 1)
) (
  input  logic          ClkxCI,
  input  logic          RstxBI,
  input  logic [63:0]   SeedxDI,
  input  logic          SeedValidxSI,
  input  logic          EnxSI,
  output logic [RW-1:0] _ZxDO,
  output logic          ZValidxSO,
  output logic          BusyxSO
);

  typedef enum logic [1:0] {StIdle, StWarm, StRun} state_e;

  // Counter value at which the last warm-up advance happens. Unused when
  // WARMUP is 0 because a seed load then goes straight to StRun.
  localparam logic [7:0] WarmLast = 8'(WARMUP - 1);

  state_e        r_state, w_state_d;
  logic [63:0]   r_s, w_s_d, w_s_adv;
  logic [7:0]    r_cnt, w_cnt_d;
  logic [RW-1:0] r_z, w_z_d;
  logic          r_zv, w_zv_d;

  // RW single-bit Fibonacci steps, unrolled into one combinational advance.
  function automatic logic [63:0] f_advance(input logic [63:0] s);
    logic [63:0] v;
    v = s;
    for (int k = 0; k < int'(RW); k++) begin
      v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    end
    return v;
  endfunction

  assign w_s_adv = f_advance(r_s);

  always_comb begin
    w_state_d = r_state;
    w_s_d     = r_s;
    w_cnt_d   = r_cnt;
    w_z_d     = r_z;
    w_zv_d    = 1'b0;
    if (SeedValidxSI) begin
      // A zero state would lock the LFSR, so map it to 1.
      w_s_d     = (SeedxDI == 64'h0) ? 64'h1 : SeedxDI;
      w_cnt_d   = 8'h0;
      w_z_d     = '0;
      w_state_d = (WARMUP == 0) ? StRun : StWarm;
    end else begin
      unique case (r_state)
        StIdle: begin
        end
        StWarm: begin
          w_s_d = w_s_adv;
          if (r_cnt != 8'hff) begin
            w_cnt_d = r_cnt + 8'h1;
          end
          if (r_cnt == WarmLast) begin
            w_state_d = StRun;
          end
        end
        StRun: begin
          if (EnxSI) begin
            w_s_d  = w_s_adv;
            w_z_d  = w_s_adv[RW-1:0];
            w_zv_d = 1'b1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_state <= StIdle;
      r_s     <= 64'h1;
      r_cnt   <= 8'h0;
      r_z     <= '0;
      r_zv    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_s     <= w_s_d;
      r_cnt   <= w_cnt_d;
      r_z     <= w_z_d;
      r_zv    <= w_zv_d;
    end
  end

  assign _ZxDO     = r_z;
  assign ZValidxSO = r_zv;
  assign BusyxSO   = (r_state != StRun);

endmodule

// File: tb/tb_dom_rand_gen.sv
// Bench for dom_rand_gen: three instances (SHARES/WARMUP = 2/0, 2/8, 3/8)
// share one randomized stimulus stream. A reference model predicts each
// instance's words into a per-instance queue; a monitor pops on ZValidxSO.
module tb_dom_rand_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] seed;
  logic        seed_v;
  logic        en;

  logic [3:0]  z_a, z_b;
  logic [11:0] z_c;
  logic [2:0]  zv, busy;
  logic [11:0] dz [3];

  always #5 clk = ~clk;

  dom_rand_gen #(.SHARES(2), .WARMUP(0)) u_dut_a (
    .ClkxCI(clk), .RstxBI(rst_n), .SeedxDI(seed), .SeedValidxSI(seed_v), .EnxSI(en),
    ._ZxDO(z_a), .ZValidxSO(zv[0]), .BusyxSO(busy[0])
  );
  dom_rand_gen #(.SHARES(2), .WARMUP(8)) u_dut_b (
    .ClkxCI(clk), .RstxBI(rst_n), .SeedxDI(seed), .SeedValidxSI(seed_v), .EnxSI(en),
    ._ZxDO(z_b), .ZValidxSO(zv[1]), .BusyxSO(busy[1])
  );
  dom_rand_gen #(.SHARES(3), .WARMUP(8)) u_dut_c (
    .ClkxCI(clk), .RstxBI(rst_n), .SeedxDI(seed), .SeedValidxSI(seed_v), .EnxSI(en),
    ._ZxDO(z_c), .ZValidxSO(zv[2]), .BusyxSO(busy[2])
  );

  assign dz[0] = {8'h0, z_a};
  assign dz[1] = {8'h0, z_b};
  assign dz[2] = z_c;

  // Reference model state, one entry per instance.
  int          rw_of   [3] = '{4, 4, 12};
  int          warm_of [3] = '{0, 8, 8};
  logic [63:0] m_s     [3];
  bit          m_seeded[3];
  int          m_left  [3];
  logic [11:0] m_z     [3];
  bit          e_valid [3];
  bit          e_busy  [3];
  logic [11:0] exp_q   [3][$];

  int n_vec = 0;
  int n_err = 0;
  bit done  = 1'b0;

  function automatic logic [63:0] lfsr_adv(input logic [63:0] s, input int n);
    logic [63:0] v;
    v = s;
    for (int k = 0; k < n; k++) v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    return v;
  endfunction

  task automatic check(input string nm, input int i, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %h want %h", nm, i, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s[i] = 64'h1; m_seeded[i] = 1'b0; m_left[i] = 0; m_z[i] = '0;
      e_valid[i] = 1'b0; e_busy[i] = 1'b1;
      exp_q[i].delete();
    end
  endtask

  // Drive one cycle of stimulus and predict the outputs after the next edge.
  task automatic step(input bit sv, input logic [63:0] sd, input bit e);
    logic [63:0] mask;
    @(negedge clk);
    seed_v = sv; seed = sd; en = e;
    for (int i = 0; i < 3; i++) begin
      mask = (64'h1 << rw_of[i]) - 64'h1;
      e_valid[i] = 1'b0;
      if (sv) begin
        m_s[i] = (sd == 64'h0) ? 64'h1 : sd;
        m_seeded[i] = 1'b1; m_left[i] = warm_of[i]; m_z[i] = '0;
      end else if (!m_seeded[i]) begin
        // unseeded: nothing moves
      end else if (m_left[i] > 0) begin
        m_s[i] = lfsr_adv(m_s[i], rw_of[i]);
        m_left[i]--;
      end else if (e) begin
        m_s[i] = lfsr_adv(m_s[i], rw_of[i]);
        m_z[i] = 12'(m_s[i] & mask);
        e_valid[i] = 1'b1;
        exp_q[i].push_back(m_z[i]);
      end
      e_busy[i] = !m_seeded[i] || (m_left[i] > 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; seed = '0; seed_v = 1'b0; en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fork
      begin : monitor
        logic [11:0] w;
        while (!done) begin
          @(posedge clk);
          #2;
          if (rst_n && !done) begin
            for (int i = 0; i < 3; i++) begin
              check("busy", i, busy[i], e_busy[i]);
              check("zvalid", i, zv[i], e_valid[i]);
              if (zv[i]) begin
                if (exp_q[i].size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL word dut%0d @%0t: got %h want <none queued>", i, $time, dz[i]);
                end else begin
                  w = exp_q[i].pop_front();
                  check("word", i, dz[i], w);
                end
              end else begin
                check("hold", i, dz[i], m_z[i]);
              end
            end
          end
        end
      end
      begin : stimulus
        // Unseeded: enable must be ignored.
        repeat (4) step(1'b0, 64'h0, 1'b1);
        // Known-answer seed on the WARMUP=0 instance.
        step(1'b1, 64'h8000_0000_0000_0000, 1'b0);
        step(1'b0, 64'h0, 1'b1);
        @(posedge clk); #3;
        check("kat_word", 0, z_a, 4'h8);
        check("kat_valid", 0, zv[0], 1'b1);
        check("kat_busy", 0, busy[0], 1'b0);
        repeat (3) step(1'b0, 64'h0, 1'b0);
        // Warm-up with enable held.
        step(1'b1, {$urandom, $urandom}, 1'b1);
        repeat (20) step(1'b0, 64'h0, 1'b1);
        // Zero seed with toggling enable.
        step(1'b1, 64'h0, 1'b0);
        repeat (30) step(1'b0, 64'h0, 1'($urandom_range(0, 1)));
        // Reseed colliding with enable in RUN: seed wins.
        step(1'b1, {$urandom, $urandom}, 1'b1);
        repeat (15) step(1'b0, 64'h0, 1'b1);
        // Asynchronous reset between edges mid-RUN.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
          check("rst_word", i, dz[i], 12'h0);
          check("rst_valid", i, zv[i], 1'b0);
          check("rst_busy", i, busy[i], 1'b1);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        seed_v = 1'b0; en = 1'b1;
        rst_n = 1'b1;
        repeat (5) step(1'b0, 64'h0, 1'b1);
        // Long random enable pattern with rare reseeds.
        step(1'b1, {$urandom, $urandom}, 1'b0);
        for (int c = 0; c < 10000; c++) begin
          step(1'($urandom_range(0, 499) == 0), {$urandom, $urandom},
               1'($urandom_range(0, 1)));
        end
        @(posedge clk); #3;
        done = 1'b1;
        for (int i = 0; i < 3; i++) check("queue_left", i, exp_q[i].size(), 0);
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
